rob_nway: RTL

Parametrised reorder buffer for the Tomasulo core. Sits between the issue queue/reservation stations and the register file and d-cache. Allocates a tag per dispatched instruction and accepts results from `NUM_WB` CDB channels. Retires in program order, one instruction per cycle, and performs a single-cycle flush on a mispredicted branch at commit.

---
 rtl/rob_nway_pkg.sv | 23 ++
 rtl/rob_nway_if.sv | 55 +++++
 rtl/rob_nway_ptr_ctrl.sv | 62 ++++++
 rtl/rob_nway.sv | 106 ++++++++++
 4 files changed

// File: rtl/rob_nway_pkg.sv
// Shared types for the Tomasulo reorder buffer: instruction class and the
// per-entry record held in the ROB array.
package tomasula_types;

  localparam int ROB_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_LD     = 2'd1,
    OP_ST     = 2'd2,
    OP_BRANCH = 2'd3
  } op_t;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  mispred;
    op_t                   op;
    logic [4:0]            rd;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_nway_if.sv
// Dispatch, CDB writeback, commit and d-cache store handshake of the ROB.
// The master side is the issue/CDB/d-cache environment; the ROB is the slave.
interface rob_nway_if #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int NUM_WB = 2,
  parameter int XLEN   = 32
);
  import tomasula_types::*;

  logic                             disp_valid;
  logic                             disp_ready;
  op_t                              disp_op;
  logic [4:0]                       disp_rd;
  logic [TAG_W-1:0]                 disp_tag;

  logic [NUM_WB-1:0]                wb_valid;
  logic [NUM_WB-1:0][TAG_W-1:0]     wb_tag;
  logic [NUM_WB-1:0][XLEN-1:0]      wb_data;
  logic [NUM_WB-1:0]                wb_mispredict;

  logic [DEPTH-1:0]                 entry_done;
  logic [DEPTH-1:0][XLEN-1:0]       entry_data;

  logic                             regfile_load;
  logic [4:0]                       commit_rd;
  logic [XLEN-1:0]                  commit_data;
  logic [TAG_W-1:0]                 commit_tag;

  logic                             data_write;
  logic                             data_mem_resp;

  logic                             flush;
  logic                             rob_empty;
  logic                             rob_full;

  modport master (
    output disp_valid, disp_op, disp_rd,
    output wb_valid, wb_tag, wb_data, wb_mispredict,
    output data_mem_resp,
    input  disp_ready, disp_tag, entry_done, entry_data,
    input  regfile_load, commit_rd, commit_data, commit_tag,
    input  data_write, flush, rob_empty, rob_full
  );

  modport slave (
    input  disp_valid, disp_op, disp_rd,
    input  wb_valid, wb_tag, wb_data, wb_mispredict,
    input  data_mem_resp,
    output disp_ready, disp_tag, entry_done, entry_data,
    output regfile_load, commit_rd, commit_data, commit_tag,
    output data_write, flush, rob_empty, rob_full
  );

endinterface

// File: rtl/rob_nway_ptr_ctrl.sv
// Head/tail pointers and occupancy count of the ROB. A flush retires the
// mispredicted branch at head and collapses the buffer to empty just past it.
module rob_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic             retire,
  input  logic             flush,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = head_q + 1'b1;
      tail_d  = head_q + 1'b1;
      count_d = '0;
    end else begin
      if (alloc)  tail_d = tail_q + 1'b1;
      if (retire) head_d = head_q + 1'b1;
      case ({alloc, retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/rob_nway.sv
// Reorder buffer: allocates tags at dispatch, collects CDB results and retires
// in program order, one per cycle, flushing on a mispredicted branch at head.
module rob_nway
  import tomasula_types::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int NUM_WB = 2,
  parameter int XLEN   = 32
) (
  input logic       clk,
  input logic       rst,
  rob_nway_if.slave bus
);

  rob_entry_t       entry_q [DEPTH];
  rob_entry_t       entry_d [DEPTH];
  rob_entry_t       head_e;

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  logic             full;
  logic             empty;

  logic             commit_valid;
  logic             flush_now;
  logic             retire;
  logic             alloc;

  rob_ptr_ctrl #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .alloc  (alloc),
    .retire (retire),
    .flush  (flush_now),
    .head   (head),
    .tail   (tail),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign head_e       = entry_q[head];
  assign commit_valid = (count != '0) && head_e.busy && head_e.done;
  assign flush_now    = commit_valid && (head_e.op == OP_BRANCH) && head_e.mispred;
  // A store stays at head until the d-cache acknowledges it.
  assign retire       = commit_valid && ((head_e.op != OP_ST) || bus.data_mem_resp);
  assign alloc        = bus.disp_valid && bus.disp_ready;

  assign bus.disp_ready   = !full && !flush_now;
  assign bus.disp_tag     = tail;
  assign bus.rob_full     = full;
  assign bus.rob_empty    = empty;
  assign bus.flush        = flush_now;
  assign bus.regfile_load = commit_valid && ((head_e.op == OP_ALU) || (head_e.op == OP_LD))
                            && (head_e.rd != 5'd0);
  assign bus.data_write   = commit_valid && (head_e.op == OP_ST);
  assign bus.commit_rd    = head_e.rd;
  assign bus.commit_data  = XLEN'(head_e.data);
  assign bus.commit_tag   = head;

  always_comb begin
    entry_d = entry_q;
    if (flush_now) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i].busy    = 1'b0;
        entry_d[i].done    = 1'b0;
        entry_d[i].mispred = 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_WB; c++) begin
        if (bus.wb_valid[c] && entry_q[bus.wb_tag[c]].busy) begin
          entry_d[bus.wb_tag[c]].done    = 1'b1;
          entry_d[bus.wb_tag[c]].data    = ROB_DATA_W'(bus.wb_data[c]);
          entry_d[bus.wb_tag[c]].mispred = bus.wb_mispredict[c]
                                           && (entry_q[bus.wb_tag[c]].op == OP_BRANCH);
        end
      end
      if (retire) begin
        entry_d[head].busy = 1'b0;
        entry_d[head].done = 1'b0;
      end
      if (alloc) begin
        entry_d[tail].busy    = 1'b1;
        entry_d[tail].done    = 1'b0;
        entry_d[tail].mispred = 1'b0;
        entry_d[tail].op      = bus.disp_op;
        entry_d[tail].rd      = (bus.disp_op == OP_ST) ? 5'd0 : bus.disp_rd;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) entry_q[gi] <= '0;
      else     entry_q[gi] <= entry_d[gi];
    end
    assign bus.entry_done[gi] = entry_q[gi].done;
    assign bus.entry_data[gi] = XLEN'(entry_q[gi].data);
  end

endmodule
